// File: rtl/cordic_vector_f32.sv
// Vectoring-mode CORDIC behind a multi-cycle custom-instruction slot.
// Returns atan2(datab, dataa) (n=0) or hypot(dataa, datab) (n=1) as an IEEE-754 single.
module cordic_vector_f32 #(
  parameter int M    = 22,
  parameter int FIXW = 28,
  parameter int FRAC = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic        n,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, ITER = 2'd2, PACK = 2'd3} state_t;

  localparam logic signed [FIXW-1:0] HALF_PI = FIXW'(32'h01921FB5);
  localparam logic [23:0]            INV_K   = 24'h9B74ED;
  localparam logic [31:0]            QNAN    = 32'h7FC00000;
  localparam logic [7:0]             EXP_OFF = 8'd127 - 8'(FRAC);

  state_t                 state_q;
  logic signed [FIXW-1:0] x_q, y_q, z_q;
  logic signed [FIXW-1:0] x_d, y_d, z_d;
  logic [4:0]             i_q;
  logic                   n_q, range_err_q, zero_q;
  logic                   done_q;
  logic [31:0]            result_q;
  logic signed [FIXW-1:0] fx_s, fy_s, mag_s;

  function automatic logic [FIXW-1:0] atan_lut(input logic [4:0] idx);
    logic [27:0] v;
    case (idx)
      5'd0:    v = 28'h0C90FDB;
      5'd1:    v = 28'h076B19C;
      5'd2:    v = 28'h03EB6EC;
      5'd3:    v = 28'h01FD5BB;
      5'd4:    v = 28'h00FFAAE;
      5'd5:    v = 28'h007FF55;
      5'd6:    v = 28'h003FFEB;
      5'd7:    v = 28'h001FFFD;
      5'd8:    v = 28'h0010000;
      5'd9:    v = 28'h0008000;
      5'd10:   v = 28'h0004000;
      5'd11:   v = 28'h0002000;
      5'd12:   v = 28'h0001000;
      5'd13:   v = 28'h0000800;
      5'd14:   v = 28'h0000400;
      5'd15:   v = 28'h0000200;
      5'd16:   v = 28'h0000100;
      5'd17:   v = 28'h0000080;
      5'd18:   v = 28'h0000040;
      5'd19:   v = 28'h0000020;
      5'd20:   v = 28'h0000010;
      5'd21:   v = 28'h0000008;
      5'd22:   v = 28'h0000004;
      5'd23:   v = 28'h0000002;
      default: v = 28'h0000000;
    endcase
    return FIXW'(v);
  endfunction

  // Denormals flush to zero; out-of-range exponents are flagged separately.
  function automatic logic [FIXW-1:0] f2fix(input logic [31:0] f);
    logic [FIXW-1:0] base;
    logic [FIXW-1:0] mag;
    logic [7:0]      sh;
    sh   = 8'd127 - f[30:23];
    base = {{(FIXW-24){1'b0}}, 1'b1, f[22:0]};
    if (f[30:23] == 8'd0 || f[30:23] > 8'd127) begin
      mag = {FIXW{1'b0}};
    end else begin
      mag = (base << (FRAC - 23)) >> sh;
    end
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fix2f(input logic [FIXW-1:0] v);
    logic [FIXW-1:0] a;
    logic [FIXW-1:0] norm;
    logic [4:0]      p;
    logic [31:0]     f;
    a = v[FIXW-1] ? -v : v;
    p = 5'd0;
    for (int k = 0; k < FIXW - 1; k++) begin
      if (a[k]) p = 5'(k);
    end
    norm = a << (FIXW - 1 - int'(p));
    if (a == {FIXW{1'b0}}) begin
      f = 32'h00000000;
    end else begin
      f = {v[FIXW-1], EXP_OFF + {3'b000, p}, 23'(norm >> (FIXW - 24))};
    end
    return f;
  endfunction

  assign fx_s  = f2fix(dataa);
  assign fy_s  = f2fix(datab);
  assign mag_s = FIXW'((53'($signed(x_q)) * 53'($signed({1'b0, INV_K}))) >>> 24);

  // Next-state datapath for quadrant pre-rotation and one micro-rotation.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    case (state_q)
      PRE: begin
        if (x_q[FIXW-1] && !y_q[FIXW-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = HALF_PI;
        end else if (x_q[FIXW-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -HALF_PI;
        end else begin
          x_d = x_q;
        end
      end
      ITER: begin
        if (!y_q[FIXW-1]) begin
          x_d = x_q + (y_q >>> i_q);
          y_d = y_q - (x_q >>> i_q);
          z_d = z_q + atan_lut(i_q);
        end else begin
          x_d = x_q - (y_q >>> i_q);
          y_d = y_q + (x_q >>> i_q);
          z_d = z_q - atan_lut(i_q);
        end
      end
      default: begin
        x_d = x_q;
      end
    endcase
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= {FIXW{1'b0}};
      y_q         <= {FIXW{1'b0}};
      z_q         <= {FIXW{1'b0}};
      i_q         <= 5'd0;
      n_q         <= 1'b0;
      range_err_q <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 32'h00000000;
    end else if (clk_en) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q         <= n;
            x_q         <= fx_s;
            y_q         <= fy_s;
            z_q         <= {FIXW{1'b0}};
            i_q         <= 5'd0;
            range_err_q <= (dataa[30:23] > 8'd127) || (datab[30:23] > 8'd127);
            zero_q      <= (fx_s == {FIXW{1'b0}}) && (fy_s == {FIXW{1'b0}});
            state_q     <= PRE;
          end
        end
        PRE: begin
          x_q     <= x_d;
          y_q     <= y_d;
          z_q     <= z_d;
          state_q <= ITER;
        end
        ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          if (i_q == 5'(M - 1)) begin
            i_q     <= 5'd0;
            state_q <= PACK;
          end else begin
            i_q <= i_q + 5'd1;
          end
        end
        PACK: begin
          done_q <= 1'b1;
          // A zero vector has no defined angle; force +0 rather than the summed LUT.
          if (range_err_q) begin
            result_q <= QNAN;
          end else if (zero_q) begin
            result_q <= 32'h00000000;
          end else begin
            result_q <= fix2f(n_q ? mag_s : z_q);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
